// File: rtl/puf_rng_collector_pkg.sv
// Shared types and default sizing for the PUF RNG word collector.
// Holds the collector FSM state encoding and the default word/FIFO dimensions.
package puf_rng_collector_pkg;

    localparam int DEFAULT_WORD_W     = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PUSH = 2'd2
    } state_t;

endpackage

// File: rtl/puf_rng_collector_if.sv
// Sample strobe from the PUF core plus the packed-word stream towards the consumer.
// slave = collector side, master = PUF core / consumer side.
interface puf_rng_collector_if
    import puf_rng_collector_pkg::*;
#(
    parameter int WORD_W = DEFAULT_WORD_W
) ();

    logic              bit_valid;
    logic [1:0]        bit_data;
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport slave (
        input  bit_valid,
        input  bit_data,
        input  word_ready,
        output word_valid,
        output word_data
    );

    modport master (
        output bit_valid,
        output bit_data,
        output word_ready,
        input  word_valid,
        input  word_data
    );

endinterface

// File: rtl/puf_word_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count; DEPTH is a power of two >= 2.
// Latency: a write is visible at rd_data one cycle later; reads are combinational from the head.
// Backpressure: writes when full are refused unless a read happens in the same cycle.
module puf_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH by overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/puf_rng_collector.sv
// Packs 2-bit PUF RNG samples (raw or von Neumann debiased) into words and queues them.
// Latency: the word completed by the sample accepted at edge k is written to the FIFO at edge k+1.
// Backpressure: none towards the PUF; a completed word meeting a full FIFO is dropped and flagged sticky.
module puf_rng_collector
    import puf_rng_collector_pkg::*;
#(
    parameter int WORD_W      = DEFAULT_WORD_W,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    localparam int CNT_W      = $clog2(WORD_W) + 1,
    localparam int FCNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 collect_en,
    input  logic                 debias_en,
    input  logic                 clr_ovf,
    puf_rng_collector_if.slave   bus,
    output logic [FCNT_W-1:0]    fifo_count,
    output logic                 overflow
);

    state_t            state;
    state_t            state_nxt;
    logic              bit_valid_q;
    logic              debias_q;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  bit_inc;
    logic              sample_acc;
    logic              word_full;
    logic              push_en;
    logic              clr_word;
    logic              pop;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;

    // The edge register tracks bit_valid in every state, so a strobe that is
    // high during PUSH or IDLE can never look like a fresh edge afterwards.
    assign sample_acc = bus.bit_valid && !bit_valid_q && (state == RUN) && collect_en;
    assign word_full  = sample_acc && ((cnt + bit_inc) == CNT_W'(WORD_W));

    always_comb begin
        bit_inc   = '0;
        shreg_nxt = shreg;
        if (debias_q) begin
            // 01 -> 0 and 10 -> 1, i.e. the kept bit is bit_data[1].
            if (bus.bit_data[1] ^ bus.bit_data[0]) begin
                bit_inc   = CNT_W'(1);
                shreg_nxt = {shreg[WORD_W-2:0], bus.bit_data[1]};
            end
        end else begin
            bit_inc   = CNT_W'(2);
            shreg_nxt = {shreg[WORD_W-3:0], bus.bit_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_en   = 1'b0;
        clr_word  = 1'b0;
        case (state)
            IDLE: begin
                if (collect_en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!collect_en) begin
                    state_nxt = IDLE;
                    clr_word  = 1'b1;
                end else if (word_full) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                push_en   = 1'b1;
                clr_word  = 1'b1;
                state_nxt = collect_en ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                clr_word  = 1'b1;
            end
        endcase
    end

    assign pop  = bus.word_valid && bus.word_ready;
    assign drop = push_en && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_valid_q <= 1'b0;
            debias_q    <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
            overflow    <= 1'b0;
        end else begin
            bit_valid_q <= bus.bit_valid;
            if ((state == IDLE) && collect_en) begin
                debias_q <= debias_en;
            end
            if (clr_word) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (sample_acc && (bit_inc != '0)) begin
                shreg <= shreg_nxt;
                cnt   <= cnt + bit_inc;
            end
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    puf_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_en),
        .wr_data (shreg),
        .rd_en   (bus.word_ready),
        .rd_data (bus.word_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.word_valid = !fifo_empty;

endmodule

// File: tb/tb_puf_rng_collector.sv
// Directed + randomized bench for puf_rng_collector with a bit-list / word-queue reference model.
module tb_puf_rng_collector;

    localparam int W   = 32;
    localparam int D   = 4;
    localparam int FCW = $clog2(D) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           collect_en = 1'b0;
    logic           debias_en = 1'b0;
    logic           clr_ovf = 1'b0;
    logic [FCW-1:0] fifo_count;
    logic           overflow;

    int checks = 0;
    int failures = 0;

    puf_rng_collector_if #(.WORD_W(W)) bus_if ();

    puf_rng_collector #(
        .WORD_W     (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .collect_en (collect_en),
        .debias_en  (debias_en),
        .clr_ovf    (clr_ovf),
        .bus        (bus_if),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: collected bits in arrival order, queued words, sticky flag.
    bit          m_bits[$];
    logic [W-1:0] m_fq[$];
    bit          m_ovf = 1'b0;
    bit          m_run = 1'b0;
    bit          m_deb = 1'b0;
    int          words_made = 0;
    bit          pop_at_push = 1'b0;
    bit          clr_at_push = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [1:0] d, input int hold);
        logic [W-1:0] w;
        @(negedge clk);
        bus_if.bit_valid = 1'b1;
        bus_if.bit_data  = d;
        repeat (hold) @(negedge clk);
        bus_if.bit_valid = 1'b0;
        bus_if.bit_data  = 2'b00;
        if (m_run) begin
            if (!m_deb) begin
                m_bits.push_back(d[1]);
                m_bits.push_back(d[0]);
            end else if (d == 2'b01) begin
                m_bits.push_back(1'b0);
            end else if (d == 2'b10) begin
                m_bits.push_back(1'b1);
            end
        end
        if (m_bits.size() >= W) begin
            w = '0;
            for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
            m_bits.delete();
            words_made++;
            if (pop_at_push) begin
                chk("pushpop_vld", bus_if.word_valid, 1'b1);
                chk("pushpop_dat", bus_if.word_data, m_fq[0]);
                bus_if.word_ready = 1'b1;
                void'(m_fq.pop_front());
            end
            if (clr_at_push) clr_ovf = 1'b1;
            if (m_fq.size() < D) m_fq.push_back(w);
            else m_ovf = 1'b1;
            if (pop_at_push || clr_at_push) begin
                settle();
                bus_if.word_ready = 1'b0;
                clr_ovf = 1'b0;
            end
        end
    endtask

    task automatic send_word_rand();
        int start;
        int n;
        start = words_made;
        n = 0;
        while ((words_made == start) && (n < 2000)) begin
            send_sample(2'($urandom_range(0, 3)), 1);
            n++;
        end
        if (words_made == start) begin
            failures++;
            $display("FAIL word_gen no word completed after %0d samples (required one)", n);
        end
    endtask

    task automatic pop_one(input string tag);
        bit ne;
        ne = (m_fq.size() != 0);
        chk({tag, "_vld"}, bus_if.word_valid, ne);
        if (ne) chk({tag, "_dat"}, bus_if.word_data, m_fq[0]);
        bus_if.word_ready = 1'b1;
        settle();
        bus_if.word_ready = 1'b0;
        if (ne) void'(m_fq.pop_front());
        chk({tag, "_cnt"}, fifo_count, m_fq.size());
    endtask

    task automatic go_run(input bit deb);
        @(negedge clk);
        collect_en = 1'b0;
        @(negedge clk);
        debias_en  = deb;
        collect_en = 1'b1;
        settle();
        m_run = 1'b1;
        m_deb = deb;
        m_bits.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus_if.bit_valid  = 1'b0;
        bus_if.bit_data   = 2'b00;
        bus_if.word_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_vld", bus_if.word_valid, 1'b0);
        chk("rst_dat", bus_if.word_data, '0);
        chk("rst_cnt", fifo_count, '0);
        chk("rst_ovf", overflow, 1'b0);
        rst = 1'b0;

        // Raw 10 pattern and push latency
        go_run(1'b0);
        for (int i = 0; i < 16; i++) send_sample(2'b10, 1);
        chk("lat_pre_vld", bus_if.word_valid, 1'b0);
        settle();
        chk("lat_post_vld", bus_if.word_valid, 1'b1);
        chk("raw_aa", bus_if.word_data, 32'hAAAA_AAAA);
        pop_one("t1");

        // Held strobe counts once
        send_sample(2'b11, 5);
        for (int i = 0; i < 15; i++) send_sample(2'($urandom_range(0, 3)), 1);
        settle();
        pop_one("hold");

        // debias_en change while running must be ignored
        debias_en = 1'b1;
        send_word_rand();
        settle();
        pop_one("deb_ign");

        // Debias mode with junk samples mixed in
        go_run(1'b1);
        debias_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            int junk;
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) send_sample(($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 1);
            send_sample((i % 2 == 0) ? 2'b01 : 2'b10, 1);
        end
        settle();
        chk("deb_55", bus_if.word_data, 32'h5555_5555);
        pop_one("deb55");
        send_word_rand();
        settle();

        // Partial word discarded on collect_en drop; FIFO retained; IDLE samples ignored
        go_run(1'b0);
        for (int i = 0; i < 10; i++) send_sample(2'($urandom_range(0, 3)), 1);
        @(negedge clk);
        collect_en = 1'b0;
        m_run = 1'b0;
        m_bits.delete();
        for (int i = 0; i < 3; i++) send_sample(2'b10, 1);
        @(negedge clk);
        collect_en = 1'b1;
        settle();
        m_run = 1'b1;
        for (int i = 0; i < 16; i++) send_sample(2'b11, 1);
        settle();
        chk("idle_cnt", fifo_count, 2);
        pop_one("deb_rand");
        chk("drop_ff", bus_if.word_data, 32'hFFFF_FFFF);
        pop_one("ff");

        // Overflow with no consumer
        for (int i = 0; i < 5; i++) send_word_rand();
        settle();
        chk("ovf_cnt", fifo_count, 4);
        chk("ovf_set", overflow, m_ovf);
        for (int i = 0; i < 4; i++) pop_one("ovf_pop");
        @(negedge clk);
        clr_ovf = 1'b1;
        settle();
        clr_ovf = 1'b0;
        m_ovf = 1'b0;
        chk("ovf_clr", overflow, m_ovf);

        // Push with simultaneous pop at full, then drop with coincident clear
        for (int i = 0; i < 4; i++) send_word_rand();
        settle();
        pop_at_push = 1'b1;
        send_word_rand();
        pop_at_push = 1'b0;
        chk("pp_cnt", fifo_count, m_fq.size());
        chk("pp_ovf", overflow, m_ovf);
        clr_at_push = 1'b1;
        send_word_rand();
        clr_at_push = 1'b0;
        chk("setwins_ovf", overflow, m_ovf);
        pop_one("pre_rst");

        // Reset during PUSH with 3 words queued
        for (int i = 0; i < 15; i++) send_sample(2'($urandom_range(0, 3)), 1);
        @(negedge clk);
        bus_if.bit_valid = 1'b1;
        bus_if.bit_data  = 2'($urandom_range(0, 3));
        @(negedge clk);
        bus_if.bit_valid = 1'b0;
        rst = 1'b1;
        m_fq.delete();
        m_bits.delete();
        m_ovf = 1'b0;
        m_run = 1'b0;
        #1;
        chk("rstp_vld", bus_if.word_valid, 1'b0);
        chk("rstp_cnt", fifo_count, m_fq.size());
        chk("rstp_ovf", overflow, m_ovf);
        chk("rstp_dat", bus_if.word_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // Collection restarts cleanly after reset
        go_run(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_word_rand();
            settle();
            pop_one("post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
